// File: rtl/eth_tx_lane_adapter.sv
// eth_tx_lane_adapter: buffers MAC frames, prepends preamble/SFD and serialises them
// onto a GMII byte lane or MII nibble lane with IFG enforcement and underrun abort.
module eth_tx_lane_adapter #(
    parameter int OUT_W           = 8,
    parameter int DEPTH           = 2048,
    parameter int START_THRESH    = 64,
    parameter int IFG_BYTES       = 12,
    parameter bit INSERT_PREAMBLE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             nibble_mode,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [OUT_W-1:0] txd,
    output logic             tx_en,
    output logic             tx_er,
    output logic [15:0]      frame_cnt,
    output logic [15:0]      underrun_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {IDLE, PRE, DATA, ABORT, IFG} state_t;

    state_t st, st_n;
    logic [8:0] mem [DEPTH];
    logic [8:0] rd_word;
    logic [LW-1:0] wr_ptr, rd_ptr, level, frames_buf;
    logic [15:0] cnt, cnt_n;
    logic [7:0] cur, cur_n, sym;
    logic cur_last, last_n, half, half_n, nib, nib_n, en_n, er_n;
    logic rdy, drain, full, empty, start_ok, boundary;
    logic begin_frame, next_data, pop, abort_now, acc, discard, wr_en;

    assign level    = wr_ptr - rd_ptr;
    assign full     = level[AW];
    assign empty    = level == '0;
    assign in_ready = rdy & (drain | ~full);
    assign acc      = in_valid & in_ready;
    // a byte arriving in the same cycle as the underrun belongs to the aborted frame
    assign discard  = drain | abort_now;
    assign wr_en    = acc & ~discard;
    assign rd_word  = mem[rd_ptr[AW-1:0]];
    assign start_ok = ~drain & (frames_buf != '0 || 32'(level) >= START_THRESH);
    assign boundary = (st == IDLE) | ~nib | half;

    always_ff @(posedge clk)
        if (wr_en) mem[wr_ptr[AW-1:0]] <= {in_last, in_data};

    always_comb begin
        st_n        = st;
        cnt_n       = cnt;
        cur_n       = cur;
        last_n      = cur_last;
        nib_n       = nib;
        half_n      = ~boundary;
        begin_frame = 1'b0;
        next_data   = 1'b0;
        pop         = 1'b0;
        abort_now   = 1'b0;
        if (boundary) begin
            case (st)
                IDLE: begin_frame = start_ok;
                PRE: begin
                    next_data = cnt == 16'd7;
                    cnt_n     = cnt + 16'd1;
                    cur_n     = cnt == 16'd6 ? 8'hD5 : 8'h55;
                end
                DATA: begin
                    st_n      = cur_last ? IFG : DATA;
                    cnt_n     = '0;
                    next_data = ~cur_last;
                end
                ABORT: begin
                    st_n  = IFG;
                    cnt_n = '0;
                end
                IFG: begin
                    begin_frame = cnt == 16'(IFG_BYTES - 1) && start_ok;
                    st_n        = cnt == 16'(IFG_BYTES - 1) ? IDLE : IFG;
                    cnt_n       = cnt + 16'd1;
                end
                default: st_n = IDLE;
            endcase
            if (begin_frame) begin
                nib_n     = nibble_mode | (OUT_W == 4);
                st_n      = PRE;
                cnt_n     = '0;
                cur_n     = 8'h55;
                next_data = ~INSERT_PREAMBLE;
            end
            if (next_data) begin
                pop       = ~empty;
                abort_now = empty;
                st_n      = empty ? ABORT : DATA;
                cur_n     = empty ? 8'h00 : rd_word[7:0];
                last_n    = ~empty & rd_word[8];
            end
        end
        en_n = st_n inside {PRE, DATA, ABORT};
        er_n = st_n == ABORT;
        sym  = half_n ? {4'h0, cur_n[7:4]} : (nib_n ? {4'h0, cur_n[3:0]} : cur_n);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st           <= IDLE;
            cnt          <= '0;
            cur          <= '0;
            cur_last     <= 1'b0;
            half         <= 1'b0;
            nib          <= 1'b0;
            tx_en        <= 1'b0;
            tx_er        <= 1'b0;
            txd          <= '0;
            rdy          <= 1'b0;
            drain        <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            frames_buf   <= '0;
            frame_cnt    <= '0;
            underrun_cnt <= '0;
        end else begin
            st         <= st_n;
            cnt        <= cnt_n;
            cur        <= cur_n;
            cur_last   <= last_n;
            half       <= half_n;
            nib        <= nib_n;
            tx_en      <= en_n;
            tx_er      <= er_n;
            txd        <= en_n ? sym[OUT_W-1:0] : '0;
            rdy        <= 1'b1;
            wr_ptr     <= wr_ptr + LW'(wr_en);
            rd_ptr     <= rd_ptr + LW'(pop);
            frames_buf <= frames_buf + LW'(wr_en & in_last) - LW'(pop & rd_word[8]);
            if (pop && rd_word[8] && frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
            if (abort_now && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
            if (acc && in_last && discard) drain <= 1'b0;
            else if (abort_now) drain <= 1'b1;
        end
    end
endmodule

// File: tb/tb_eth_tx_lane_adapter.sv
// tb_eth_tx_lane_adapter: stimulus queues expected PHY frames; an independent monitor
// decodes the lane, pops the scoreboard and compares data, timing and counters.
module tb_eth_tx_lane_adapter;
    localparam int IFG = 12;

    typedef struct {int n; bit nib; bit abort; int gap;} rec_t;

    logic clk = 0, rst_n = 0, nibble_mode = 0, in_valid = 0, in_last = 0;
    logic [7:0] in_data = '0;
    logic in_ready, tx_en, tx_er;
    logic [7:0] txd;
    logic [15:0] frame_cnt, underrun_cnt;
    logic sf_valid = 0, sf_ready, sf_en, sf_er;
    logic [7:0] sf_txd;
    logic [15:0] sf_fc, sf_uc;

    int checks = 0, passes = 0;
    rec_t recs[$];
    logic [7:0] exp_bytes[$];
    int exp_fc = 0, exp_uc = 0;
    logic [7:0] fbuf [256];

    always #5 clk = ~clk;

    eth_tx_lane_adapter #(.OUT_W(8), .DEPTH(256), .START_THRESH(16), .IFG_BYTES(IFG), .INSERT_PREAMBLE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .nibble_mode(nibble_mode), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .txd(txd), .tx_en(tx_en), .tx_er(tx_er),
        .frame_cnt(frame_cnt), .underrun_cnt(underrun_cnt)
    );

    eth_tx_lane_adapter #(.OUT_W(8), .DEPTH(16), .START_THRESH(32), .IFG_BYTES(IFG), .INSERT_PREAMBLE(1'b1)) u_sf (
        .clk(clk), .rst_n(rst_n), .nibble_mode(1'b0), .in_data(8'h5A), .in_valid(sf_valid),
        .in_last(1'b0), .in_ready(sf_ready), .txd(sf_txd), .tx_en(sf_en), .tx_er(sf_er),
        .frame_cnt(sf_fc), .underrun_cnt(sf_uc)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic fill(input int off, input int len);
        for (int i = 0; i < len; i++) fbuf[off + i] = 8'($urandom);
    endtask

    // Expected wire image: 7 x 0x55, 0xD5, then the payload; aborted frames end in one error byte-time.
    task automatic expect_frame(input int off, input int len, input bit nib, input bit abort, input int gap);
        recs.push_back('{n: len + 8, nib: nib, abort: abort, gap: gap});
        repeat (7) exp_bytes.push_back(8'h55);
        exp_bytes.push_back(8'hD5);
        for (int i = 0; i < len; i++) exp_bytes.push_back(fbuf[off + i]);
    endtask

    task automatic drive(input int first, input int last_i, input bit mark_last, input int gap_max);
        for (int i = first; i <= last_i; i++) begin
            int t;
            bit r;
            t = 0;
            in_data  = fbuf[i];
            in_last  = mark_last && i == last_i;
            in_valid = 1;
            do begin
                @(negedge clk);
                r = in_ready;
                @(posedge clk);
                #1;
                t++;
            end while (!r && t < 3000);
            if (!r) chk("push_accepted", r, 1);
            in_valid = 0;
            in_last  = 0;
            t = $urandom_range(gap_max, 0);
            repeat (t) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((recs.size() != 0 || tx_en) && t < 20000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 20000) chk("idle_timeout_pending_frames", recs.size(), 0);
        repeat (30) @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        rec_t r;
        logic [7:0] got[$];
        logic [3:0] lo;
        bit in_fr, bogus, half, seen_fall;
        int cyc, fall_cyc, en_c, er_c, hi_bad, er_txd, mm, bt, prev_bt, gap, min_gap;
        in_fr = 0; bogus = 0; half = 0; seen_fall = 0; lo = '0;
        cyc = 0; fall_cyc = 0; en_c = 0; er_c = 0; hi_bad = 0; er_txd = 0; prev_bt = 1;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                in_fr = 0;
                seen_fall = 0;
            end else begin
                if (tx_en && !in_fr) begin
                    in_fr = 1; got.delete(); en_c = 0; er_c = 0; hi_bad = 0; er_txd = 0; half = 0;
                    bogus = recs.size() == 0;
                    if (bogus) chk("unexpected_frame_queue_size", recs.size(), 1);
                    else begin
                        r = recs.pop_front();
                        gap = cyc - fall_cyc;
                        min_gap = IFG * prev_bt;
                        if (seen_fall && r.gap >= 0) chk("ifg_exact_cycles", gap, r.gap);
                        else if (seen_fall) chk("ifg_min_cycles", gap >= min_gap ? min_gap : gap, min_gap);
                    end
                end
                if (tx_en) begin
                    en_c++;
                    if (tx_er) begin
                        er_c++;
                        if (txd != 0) er_txd++;
                    end else if (!bogus && r.nib) begin
                        if (txd[7:4] != 0) hi_bad++;
                        if (!half) lo = txd[3:0];
                        else got.push_back({txd[3:0], lo});
                        half = !half;
                    end else got.push_back(txd);
                end else if (in_fr) begin
                    in_fr = 0;
                    seen_fall = 1;
                    fall_cyc = cyc;
                    chk("tx_er_at_fall", tx_er, 0);
                    if (!bogus) begin
                        bt = r.nib ? 2 : 1;
                        chk("tx_en_cycles", en_c, (r.n + int'(r.abort)) * bt);
                        chk("tx_er_cycles", er_c, int'(r.abort) * bt);
                        chk("frame_byte_count", got.size(), r.n);
                        mm = 0;
                        for (int i = 0; i < r.n; i++) begin
                            logic [7:0] e;
                            e = exp_bytes.pop_front();
                            if (i >= got.size() || got[i] != e) mm++;
                        end
                        chk("frame_byte_mismatches", mm, 0);
                        if (r.nib) chk("upper_nibble_nonzero", hi_bad, 0);
                        if (r.abort) chk("abort_txd_nonzero", er_txd, 0);
                        if (r.abort) exp_uc++;
                        else exp_fc++;
                        chk("frame_cnt", frame_cnt, exp_fc);
                        chk("underrun_cnt", underrun_cnt, exp_uc);
                        prev_bt = bt;
                    end
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int acc, sf_tx, len, gmax;
        time t0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx_en", tx_en, 0);
        chk("reset_tx_er", tx_er, 0);
        chk("reset_txd", txd, 0);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_frame_cnt", frame_cnt, 0);
        chk("reset_underrun_cnt", underrun_cnt, 0);
        rst_n = 1;
        @(posedge clk);
        #1;
        chk("in_ready_after_reset", in_ready, 1);

        // small FIFO, threshold above depth: fills and stalls without starting
        sf_valid = 1; acc = 0; sf_tx = 0;
        repeat (24) begin
            @(negedge clk);
            acc += int'(sf_ready);
            sf_tx += int'(sf_en);
            @(posedge clk);
            #1;
        end
        sf_valid = 0;
        chk("sf_accepted_bytes", acc, 16);
        chk("sf_in_ready_when_full", sf_ready, 0);
        chk("sf_no_transmit", sf_tx, 0);

        for (int i = 0; i < 64; i++) fbuf[i] = 8'(i);
        expect_frame(0, 64, 0, 0, -1);
        drive(0, 63, 1, 0);
        wait_idle();

        nibble_mode = 1;
        fbuf[0] = 8'hA5; fbuf[1] = 8'h3C;
        expect_frame(0, 2, 1, 0, -1);
        drive(0, 1, 1, 0);
        wait_idle();

        for (int m = 0; m < 2; m++) begin
            nibble_mode = m[0];
            fill(0, 128);
            expect_frame(0, 64, m[0], 0, -1);
            expect_frame(64, 64, m[0], 0, m == 0 ? IFG : 2 * IFG);
            drive(0, 63, 1, 0);
            drive(64, 127, 1, 0);
            wait_idle();
        end

        nibble_mode = 0;
        fill(0, 130);
        expect_frame(0, 20, 0, 1, -1);
        drive(0, 19, 0, 0);
        repeat (60) @(posedge clk);
        #1;
        t0 = $time;
        drive(20, 99, 1, 0);
        chk("drain_accept_cycles", ($time - t0) / 10, 80);
        expect_frame(100, 30, 0, 0, -1);
        drive(100, 129, 1, 0);
        wait_idle();

        fill(0, 64);
        expect_frame(0, 64, 0, 0, -1);
        drive(0, 63, 1, 0);
        repeat (3) @(posedge clk);
        #3;
        chk("tx_en_before_reset", tx_en, 1);
        rst_n = 0;
        #1;
        chk("async_reset_tx_en", tx_en, 0);
        chk("async_reset_tx_er", tx_er, 0);
        chk("async_reset_txd", txd, 0);
        recs.delete(); exp_bytes.delete(); exp_fc = 0; exp_uc = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        @(posedge clk);
        #1;
        chk("frame_cnt_after_reset", frame_cnt, 0);
        chk("underrun_cnt_after_reset", underrun_cnt, 0);
        fill(0, 40);
        expect_frame(0, 40, 0, 0, -1);
        drive(0, 39, 1, 0);
        wait_idle();

        for (int m = 0; m < 2; m++) begin
            nibble_mode = m[0];
            repeat (6) begin
                if ($urandom_range(1, 0) == 1) begin
                    len = $urandom_range(15, 1);
                    gmax = 3;
                end else begin
                    len = $urandom_range(60, 17);
                    gmax = 0;
                end
                fill(0, len);
                expect_frame(0, len, m[0], 0, -1);
                drive(0, len - 1, 1, gmax);
                repeat ($urandom_range(20, 0)) @(posedge clk);
                #1;
            end
            wait_idle();
        end

        chk("leftover_expected_bytes", exp_bytes.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/eth_tx_lane_adapter.md
# eth_tx_lane_adapter

Parametrised transmit-path adapter between the PS Ethernet MAC byte stream (EMIO) and the PL-side PHY pins. It buffers frames in a FIFO, inserts preamble/SFD, and serialises bytes onto an 8-bit GMII or 4-bit MII lane. The nibble/byte lane mode is selectable at run time. It also enforces inter-frame gap, detects underrun (aborting the frame with tx_er), and keeps status counters. It sits in the top level between the block-design MAC interface and the ETH_TXD/ETH_TXCTL pins, clocked by the PHY TX clock.

## Interface
Parameters:
- OUT_W, 8: PHY data width, 4 or 8.
- DEPTH, 2048: FIFO depth in bytes, power of two.
- START_THRESH, 64: buffered-byte level that starts a frame before its last byte has arrived (cut-through).
- IFG_BYTES, 12: minimum inter-frame gap, in byte-times.
- INSERT_PREAMBLE, 1: when 1, prepend 7×0x55 + 0xD5.

Ports:
- clk  in  1  PHY TX clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- nibble_mode  in  1  1 = 4-bit lane (MII); forced to 1 when OUT_W=4.
- in_data  in  8  frame byte from the MAC.
- in_valid  in  1  in_data is valid.
- in_last  in  1  last byte of the frame.
- in_ready  out  1  the adapter accepts the byte.
- txd  out  OUT_W  PHY transmit data.
- tx_en  out  1  PHY transmit enable.
- tx_er  out  1  PHY transmit error.
- frame_cnt  out  16  frames sent to completion, saturating.
- underrun_cnt  out  16  aborted frames, saturating.

## Operation
- Write side:
  - A byte is accepted when in_valid & in_ready.
  - in_ready = !fifo_full, except in drain mode, where in_ready=1 and bytes are discarded.
  - Each FIFO entry stores {last, data}.
  - frames_buffered is incremented on a written last byte and decremented when a frame is dequeued.
- FSM states: IDLE, PRE, DATA, ABORT, IFG.
- IDLE:
  - Starts a frame when frames_buffered>0 OR fifo_level>=START_THRESH.
  - nibble_mode is latched here and held for the whole frame.
  - Next state is PRE if INSERT_PREAMBLE=1, otherwise DATA.
- PRE: sends 8 byte-times (7×0x55, then 0xD5), then goes to DATA.
- DATA:
  - Pops one byte per byte-time.
  - On a popped byte with last=1: frame_cnt++, go to IFG.
  - If the FIFO is empty when a byte is needed (underrun), go to ABORT.
- ABORT:
  - Drives one byte-time with tx_en=1, tx_er=1, txd=0; underrun_cnt++.
  - Sets drain mode, which stays active until an accepted byte has in_last=1.
  - Then goes to IFG.
- IFG:
  - tx_en=0 for IFG_BYTES byte-times, then IDLE.
  - A drain still in progress does not block IFG, but IDLE must not start a new frame while drain is active.
- Byte-time:
  - 1 cycle in byte mode.
  - 2 cycles in nibble mode: low nibble first, then high nibble, on txd[3:0]; txd[OUT_W-1:4]=0.
- Counters stick at 0xFFFF.
- Full FIFO with no complete frame and level ≥ START_THRESH: cut-through start guarantees the FIFO drains, so there is no deadlock. START_THRESH ≤ DEPTH is required.

## Timing
- Reset values (while rst_n=0 and after release):
  - txd=0, tx_en=0, tx_er=0, in_ready=0.
  - Counters 0, FIFO empty, drain cleared, FSM in IDLE.
- in_ready goes high the first cycle after rst_n deasserts.
- Reset mid-frame: outputs go to 0 immediately (asynchronously); the partial frame is lost.
- All PHY outputs are registered.
- Start condition true in IDLE at cycle N → tx_en=1 with the first symbol at N+1.
- A byte written at cycle N is visible to the start condition at N+1 (FIFO level is updated by a registered write).
- tx_en is continuous for the whole frame. It drops in the cycle after the last symbol, and tx_er=0 at that point.
- The gap between frames is exactly IFG_BYTES byte-times when the next frame is ready.
- A simultaneous push and pop on a full FIFO is allowed only if in_ready was high. Level is unchanged.
- Underrun is detected in the cycle the pop is attempted. The tx_er symbol follows in the next byte-time.

## Test plan
- Byte mode, 64-byte frame 0x00..0x3F, store-and-forward: tx_en high for 72 cycles; txd=55×7, D5, then 00..3F. frame_cnt=1.
- Nibble mode (OUT_W=8), frame {0xA5,0x3C}: txd sequence after SFD is 5,A,C,3. tx_en high for 20 cycles; txd[7:4]=0.
- Two back-to-back fully buffered 64-byte frames in byte mode: the second tx_en rises exactly 12 cycles after the first falls. Nibble mode gives 24 cycles.
- START_THRESH=16; stall in_valid after 20 bytes of a 100-byte frame:
  - One tx_er=1 cycle.
  - underrun_cnt=1, frame_cnt=0.
  - Bytes 21..100 are accepted and discarded.
  - The next frame transmits intact.
- DEPTH=16, START_THRESH=32 (forced store-and-forward unit test), MAC pushes 20 bytes: in_ready=0 after 16 bytes, with no data corruption or loss.
- Assert rst_n=0 mid-DATA: tx_en, tx_er and txd go to 0 immediately. After release, a new frame transmits normally and the counters read 0.
